// File: rtl/sram_axi_bridge_pkg.sv
// Shared widths, AXI id constants and FSM encodings for the SRAM-like to AXI bridge.
package sram_axi_bridge_pkg;
   localparam int INST_REQ_W = 34;
   localparam int DATA_REQ_W = 71;
   localparam int AR_W       = 39;
   localparam int AW_W       = 35;
   localparam int W_W        = 36;
   localparam int R_W        = 36;

   localparam logic [3:0] ARID_INST = 4'd0;
   localparam logic [3:0] ARID_DATA = 4'd1;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_SEND = 1'b1
   } ar_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_SEND = 2'd1,
      W_RESP = 2'd2
   } w_state_t;
endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges an instruction read port and a data read/write port (SRAM-like) onto one AXI master.
// Handshake: a transfer happens in any cycle where valid and ready are both 1; valid holds its payload until then.
module sram_axi_bridge
   import sram_axi_bridge_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inst_req,
   input  logic [INST_REQ_W-1:0] inst_req_bus,
   output logic                  inst_addr_ok,
   output logic                  inst_data_ok,
   output logic [31:0]           inst_rdata,
   input  logic                  data_req,
   input  logic [DATA_REQ_W-1:0] data_req_bus,
   output logic                  data_addr_ok,
   output logic                  data_data_ok,
   output logic [31:0]           data_rdata,
   output logic                  arvalid,
   output logic [AR_W-1:0]       ar_bus,
   input  logic                  arready,
   input  logic                  rvalid,
   input  logic [R_W-1:0]        r_bus,
   output logic                  rready,
   output logic                  awvalid,
   output logic [AW_W-1:0]       aw_bus,
   input  logic                  awready,
   output logic                  wvalid,
   output logic [W_W-1:0]        w_bus,
   input  logic                  wready,
   input  logic                  bvalid,
   output logic                  bready
);
   ar_state_t ar_state, ar_next;
   w_state_t  w_state, w_next;
   logic      inst_out, data_out;
   logic      aw_done, w_done;
   logic      inst_rd_ok, data_rd_ok, data_wr_ok;
   logic      rid_inst, rid_data, aw_hs, w_hs;

   wire       data_wr = data_req_bus[70];

   // Data read wins arbitration; the inst read is only taken when no data read is taken.
   assign data_rd_ok = !reset && data_req && !data_wr && (ar_state == AR_IDLE)
                       && !data_out && (w_state == W_IDLE);
   assign data_wr_ok = !reset && data_req && data_wr && (w_state == W_IDLE) && !data_out;
   assign inst_rd_ok = !reset && inst_req && (ar_state == AR_IDLE) && !inst_out && !data_rd_ok;

   assign inst_addr_ok = inst_rd_ok;
   assign data_addr_ok = data_rd_ok || data_wr_ok;

   assign rid_inst = !reset && rvalid && (r_bus[35:32] == ARID_INST);
   assign rid_data = !reset && rvalid && (r_bus[35:32] == ARID_DATA);
   assign rready       = !reset;
   assign inst_data_ok = rid_inst;
   assign data_data_ok = rid_data || (!reset && (w_state == W_RESP) && bvalid);
   assign inst_rdata   = r_bus[31:0];
   assign data_rdata   = r_bus[31:0];

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ar_state <= AR_IDLE;
         w_state  <= W_IDLE;
      end else begin
         ar_state <= ar_next;
         w_state  <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      ar_next = ar_state;
      case (ar_state)
         AR_IDLE: if (data_rd_ok || inst_rd_ok) ar_next = AR_SEND;
         AR_SEND: if (arready) ar_next = AR_IDLE;
         default: ar_next = AR_IDLE;
      endcase
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE: if (data_wr_ok) w_next = W_SEND;
         W_SEND: if ((aw_done || aw_hs) && (w_done || w_hs)) w_next = W_RESP;
         W_RESP: if (bvalid) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      arvalid = !reset && (ar_state == AR_SEND);
      awvalid = !reset && (w_state == W_SEND) && !aw_done;
      wvalid  = !reset && (w_state == W_SEND) && !w_done;
      bready  = !reset && (w_state == W_RESP);
   end

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   // Outstanding-read flags and per-channel completion flags for the write
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_out <= 1'b0;
         data_out <= 1'b0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         inst_out <= (inst_out && !rid_inst) || inst_rd_ok;
         data_out <= (data_out && !rid_data) || data_rd_ok;
         if (data_wr_ok) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
         end
      end
   end

   // Payload latches only load on acceptance, so they stay put while valid is high
   always_ff @(posedge clk) begin
      if (reset) begin
         ar_bus <= '0;
         aw_bus <= '0;
         w_bus  <= '0;
      end else begin
         if (data_rd_ok)
            ar_bus <= {ARID_DATA, 1'b0, data_req_bus[69:68], data_req_bus[63:32]};
         else if (inst_rd_ok)
            ar_bus <= {ARID_INST, 1'b0, inst_req_bus[33:32], inst_req_bus[31:0]};
         if (data_wr_ok) begin
            aw_bus <= {1'b0, data_req_bus[69:68], data_req_bus[63:32]};
            w_bus  <= {data_req_bus[67:64], data_req_bus[31:0]};
         end
      end
   end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: read arbitration, split write handshakes, reset abandon.
module tb_sram_axi_bridge;
   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [33:0] inst_req_bus;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [70:0] data_req_bus;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        arvalid, arready, rvalid, rready;
   logic [38:0] ar_bus;
   logic [35:0] r_bus;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [34:0] aw_bus;
   logic [35:0] w_bus;

   int total = 0;
   int bad   = 0;

   sram_axi_bridge dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_req_bus(inst_req_bus),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_req_bus(data_req_bus),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arvalid(arvalid), .ar_bus(ar_bus), .arready(arready),
      .rvalid(rvalid), .r_bus(r_bus), .rready(rready),
      .awvalid(awvalid), .aw_bus(aw_bus), .awready(awready),
      .wvalid(wvalid), .w_bus(w_bus), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // inputs change 1ns after the rising edge; checks happen 2ns after that
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive_inst(input logic req, input logic [1:0] size, input logic [31:0] addr);
      inst_req     = req;
      inst_req_bus = {size, addr};
   endtask

   task automatic drive_data(input logic req, input logic wr, input logic [1:0] size,
                             input logic [3:0] strb, input logic [31:0] addr,
                             input logic [31:0] wdata);
      data_req     = req;
      data_req_bus = {wr, size, strb, addr, wdata};
   endtask

   task automatic drive_r(input logic v, input logic [3:0] id, input logic [31:0] d);
      rvalid = v;
      r_bus  = {id, d};
   endtask

   initial begin
      reset = 1'b1;
      arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      drive_inst(1'b0, 2'd0, 32'h0);
      drive_data(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      drive_r(1'b0, 4'd0, 32'h0);
      tick(); tick();

      // reset state, with requests and responses present
      drive_inst(1'b1, 2'd2, 32'h1C00_0000);
      drive_r(1'b1, 4'd0, 32'h1234_5678);
      bvalid = 1'b1;
      settle();
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_aw_w_b", {awvalid, wvalid, bready}, 0);
      chk("rst_rready", rready, 0);
      tick();
      reset = 1'b0;
      drive_inst(1'b0, 2'd0, 32'h0);
      drive_r(1'b0, 4'd0, 32'h0);
      bvalid = 1'b0;
      settle();
      chk("rready_out_of_reset", rready, 1);

      // basic inst read
      tick();
      drive_inst(1'b1, 2'd2, 32'h1C00_0000);
      arready = 1'b1;
      settle();
      chk("t1_inst_addr_ok", inst_addr_ok, 1);
      chk("t1_arvalid_c0", arvalid, 0);
      tick();
      drive_inst(1'b0, 2'd0, 32'h0);
      settle();
      chk("t1_arvalid_c1", arvalid, 1);
      chk("t1_ar_bus", ar_bus, {4'd0, 3'b010, 32'h1C00_0000});
      tick();
      drive_inst(1'b1, 2'd2, 32'h1C00_0004);
      settle();
      chk("t1_arvalid_after_hs", arvalid, 0);
      chk("t1_blocked_outstanding", inst_addr_ok, 0);
      drive_inst(1'b0, 2'd0, 32'h0);
      drive_r(1'b1, 4'd0, 32'h0280_0000);
      settle();
      chk("t1_inst_data_ok", inst_data_ok, 1);
      chk("t1_inst_rdata", inst_rdata, 32'h0280_0000);
      chk("t1_data_data_ok", data_data_ok, 0);
      tick();
      drive_r(1'b0, 4'd0, 32'h0);

      // simultaneous inst and data reads
      arready = 1'b0;
      drive_inst(1'b1, 2'd2, 32'h0000_0100);
      drive_data(1'b1, 1'b0, 2'd1, 4'h0, 32'h0000_0200, 32'h0);
      settle();
      chk("t2_data_addr_ok", data_addr_ok, 1);
      chk("t2_inst_addr_ok", inst_addr_ok, 0);
      tick();
      drive_data(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      settle();
      chk("t2_ar_bus_data", ar_bus, {4'd1, 3'b001, 32'h0000_0200});
      chk("t2_inst_wait", inst_addr_ok, 0);
      tick();
      settle();
      chk("t2_ar_bus_stable", {arvalid, ar_bus}, {1'b1, 4'd1, 3'b001, 32'h0000_0200});
      arready = 1'b1;
      tick();
      settle();
      chk("t2_inst_next", inst_addr_ok, 1);
      tick();
      drive_inst(1'b0, 2'd0, 32'h0);
      settle();
      chk("t2_ar_bus_inst", ar_bus, {4'd0, 3'b010, 32'h0000_0100});
      tick();
      drive_r(1'b1, 4'd1, 32'hAAAA_5555);
      settle();
      chk("t2_data_ok", {data_data_ok, inst_data_ok}, 2'b10);
      chk("t2_data_rdata", data_rdata, 32'hAAAA_5555);
      tick();
      drive_r(1'b1, 4'd0, 32'h5555_AAAA);
      settle();
      chk("t2_inst_ok", {data_data_ok, inst_data_ok}, 2'b01);
      tick();
      drive_r(1'b0, 4'd0, 32'h0);

      // data write, W handshake three cycles before AW
      arready = 1'b0;
      drive_data(1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
      settle();
      chk("t3_wr_addr_ok", data_addr_ok, 1);
      tick();
      drive_data(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      wready = 1'b1;
      settle();
      chk("t3_valids_c1", {awvalid, wvalid}, 2'b11);
      chk("t3_aw_bus", aw_bus, {3'b010, 32'h0000_1000});
      chk("t3_w_bus", w_bus, {4'hF, 32'hDEAD_BEEF});
      tick();
      wready = 1'b0;
      settle();
      chk("t3_wvalid_drops", {awvalid, wvalid}, 2'b10);
      tick();
      tick();
      drive_data(1'b1, 1'b0, 2'd2, 4'h0, 32'h0000_2000, 32'h0);
      awready = 1'b1;
      settle();
      chk("t3_awvalid_held", awvalid, 1);
      chk("t3_rd_blocked_send", data_addr_ok, 0);
      tick();
      awready = 1'b0;
      settle();
      chk("t3_resp_state", {awvalid, wvalid, bready}, 3'b001);
      chk("t3_rd_blocked_resp", data_addr_ok, 0);
      chk("t3_no_early_ok", data_data_ok, 0);
      tick();
      bvalid = 1'b1;
      settle();
      chk("t3_b_data_ok", data_data_ok, 1);
      chk("t3_rd_blocked_bvalid", data_addr_ok, 0);
      tick();
      bvalid = 1'b0;
      settle();
      chk("t3_rd_after_b", data_addr_ok, 1);
      chk("t3_data_ok_once", {data_data_ok, bready}, 2'b00);
      tick();
      arready = 1'b1;
      drive_data(1'b1, 1'b1, 2'd0, 4'h1, 32'h0000_3000, 32'h0000_0011);
      settle();
      chk("t3_wr_blocked_rd_out", data_addr_ok, 0);
      tick();
      drive_data(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      drive_r(1'b1, 4'd1, 32'hCAFE_F00D);
      settle();
      chk("t3_rd_data_ok", data_data_ok, 1);
      tick();
      drive_r(1'b0, 4'd0, 32'h0);

      // inst read and data write together, both write handshakes in one cycle
      drive_inst(1'b1, 2'd2, 32'h1C00_0008);
      drive_data(1'b1, 1'b1, 2'd1, 4'h3, 32'h0000_4000, 32'h0000_BEEF);
      settle();
      chk("t4_both_accepted", {inst_addr_ok, data_addr_ok}, 2'b11);
      tick();
      drive_inst(1'b0, 2'd0, 32'h0);
      drive_data(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      awready = 1'b1;
      wready  = 1'b1;
      settle();
      chk("t4_ar_bus", ar_bus, {4'd0, 3'b010, 32'h1C00_0008});
      chk("t4_aw_w", {aw_bus, w_bus}, {3'b001, 32'h0000_4000, 4'h3, 32'h0000_BEEF});
      tick();
      awready = 1'b0;
      wready  = 1'b0;
      settle();
      chk("t4_simul_resp", {arvalid, awvalid, wvalid, bready}, 4'b0001);
      bvalid = 1'b1;
      drive_r(1'b1, 4'd0, 32'h0000_0013);
      settle();
      chk("t4_both_data_ok", {inst_data_ok, data_data_ok}, 2'b11);
      tick();
      bvalid = 1'b0;
      drive_r(1'b0, 4'd0, 32'h0);

      // reset abandons a stalled read
      arready = 1'b0;
      drive_inst(1'b1, 2'd2, 32'h1C00_000C);
      tick();
      drive_inst(1'b0, 2'd0, 32'h0);
      settle();
      chk("t5_arvalid_stall", arvalid, 1);
      tick();
      reset = 1'b1;
      tick();
      settle();
      chk("t5_arvalid_reset", arvalid, 0);
      tick();
      reset = 1'b0;
      drive_inst(1'b1, 2'd1, 32'h1C00_0010);
      settle();
      chk("t5_accept_after_reset", inst_addr_ok, 1);
      tick();
      drive_inst(1'b0, 2'd0, 32'h0);
      settle();
      chk("t5_ar_bus", {arvalid, ar_bus}, {1'b1, 4'd0, 3'b001, 32'h1C00_0010});
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
